// File: rtl/ysyx_25040129_axi_arbiter_if.sv
// ysyx_25040129_axi_arbiter_if: IFU, LSU and downstream AXI signals seen by the two-master arbiter
interface ysyx_25040129_axi_arbiter_if;
  logic [31:0] ifu_araddr;
  logic [7:0]  ifu_arlen;
  logic        ifu_arvalid, ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rlast, ifu_rvalid, ifu_rready;
  logic [31:0] lsu_araddr;
  logic [2:0]  lsu_arsize;
  logic        lsu_arvalid, lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid, lsu_rready;
  logic [31:0] lsu_awaddr;
  logic        lsu_awvalid, lsu_awready;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid, lsu_wready;
  logic [1:0]  lsu_bresp;
  logic        lsu_bvalid, lsu_bready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        err;
  modport slave (
    input  ifu_araddr, ifu_arlen, ifu_arvalid, ifu_rready,
    output ifu_arready, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rvalid,
    input  lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
    output lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
    input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready,
    output lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
    output araddr, arsize, arlen, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid,
    output err
  );
  modport master (
    output ifu_araddr, ifu_arlen, ifu_arvalid, ifu_rready,
    input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rlast, ifu_rvalid,
    output lsu_araddr, lsu_arsize, lsu_arvalid, lsu_rready,
    input  lsu_arready, lsu_rdata, lsu_rresp, lsu_rvalid,
    output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid, lsu_bready,
    input  lsu_awready, lsu_wready, lsu_bresp, lsu_bvalid,
    input  araddr, arsize, arlen, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid,
    input  err
  );
endinterface

// File: rtl/ysyx_25040129_axi_arbiter.sv
// ysyx_25040129_axi_arbiter: round-robin IFU/LSU arbiter granting one whole AXI transaction at a time
module ysyx_25040129_axi_arbiter (
  input logic clk,
  input logic rst,
  ysyx_25040129_axi_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_last_lsu, r_ar_done, r_aw_done, r_w_done, r_err;
  logic w_ifu, w_lsu_rd, w_wr, w_rd, w_pick_lsu, w_rhs, w_bhs, w_err;
  assign w_ifu = r_state == IFU_RD;
  assign w_lsu_rd = r_state == LSU_RD;
  assign w_wr = r_state == LSU_WR;
  assign w_rd = w_ifu | w_lsu_rd;
  assign w_pick_lsu = (bus.lsu_awvalid | bus.lsu_arvalid) & ~(bus.ifu_arvalid & r_last_lsu);
  assign w_rhs = bus.rvalid & bus.rready;
  assign w_bhs = bus.bvalid & bus.bready;
  // a final beat with rlast closes the burst even if the count disagreed
  assign w_err = (w_rhs & ((bus.rlast & |r_cnt) | (~bus.rlast & ~|r_cnt) | |bus.rresp)) | (w_bhs & |bus.bresp);
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_pick_lsu ? (bus.lsu_awvalid ? LSU_WR : LSU_RD) : bus.ifu_arvalid ? IFU_RD : IDLE)
           : ((w_rd & w_rhs & bus.rlast) | (w_wr & w_bhs)) ? IDLE : r_state;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_lsu <= 1'b0;
      r_cnt <= 8'd0;
      r_err <= 1'b0;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done <= 1'b0;
    end else begin
      r_err <= w_err;
      r_ar_done <= (r_state != IDLE) & (r_ar_done | (bus.arvalid & bus.arready));
      r_aw_done <= (r_state != IDLE) & (r_aw_done | (bus.awvalid & bus.awready));
      r_w_done <= (r_state != IDLE) & (r_w_done | (bus.wvalid & bus.wready));
      if (r_state == IDLE && w_next != IDLE) begin
        r_last_lsu <= w_next != IFU_RD;
        r_cnt <= w_next == IFU_RD ? bus.ifu_arlen : 8'd0;
      end else if (w_rhs) begin
        r_cnt <= |r_cnt ? r_cnt - 8'd1 : 8'd0;
      end
    end
  end
  // address phases are gated once accepted so a master's next request cannot leak into this grant
  always_comb begin
    bus.araddr = w_ifu ? bus.ifu_araddr : w_lsu_rd ? bus.lsu_araddr : 32'd0;
    bus.arsize = w_ifu ? 3'b010 : w_lsu_rd ? bus.lsu_arsize : 3'd0;
    bus.arlen = w_ifu ? bus.ifu_arlen : 8'd0;
    bus.arburst = w_rd ? 2'b01 : 2'b00;
    bus.arvalid = ~r_ar_done & (w_ifu ? bus.ifu_arvalid : w_lsu_rd & bus.lsu_arvalid);
    bus.rready = w_ifu ? bus.ifu_rready : w_lsu_rd & bus.lsu_rready;
    bus.ifu_arready = w_ifu & ~r_ar_done & bus.arready;
    bus.ifu_rdata = w_ifu ? bus.rdata : 32'd0;
    bus.ifu_rresp = w_ifu ? bus.rresp : 2'b00;
    bus.ifu_rlast = w_ifu & bus.rlast;
    bus.ifu_rvalid = w_ifu & bus.rvalid;
    bus.lsu_arready = w_lsu_rd & ~r_ar_done & bus.arready;
    bus.lsu_rdata = w_lsu_rd ? bus.rdata : 32'd0;
    bus.lsu_rresp = w_lsu_rd ? bus.rresp : 2'b00;
    bus.lsu_rvalid = w_lsu_rd & bus.rvalid;
    bus.awaddr = w_wr ? bus.lsu_awaddr : 32'd0;
    bus.awvalid = w_wr & ~r_aw_done & bus.lsu_awvalid;
    bus.lsu_awready = w_wr & ~r_aw_done & bus.awready;
    bus.wdata = w_wr ? bus.lsu_wdata : 32'd0;
    bus.wstrb = w_wr ? bus.lsu_wstrb : 4'd0;
    bus.wvalid = w_wr & ~r_w_done & bus.lsu_wvalid;
    bus.lsu_wready = w_wr & ~r_w_done & bus.wready;
    bus.bready = w_wr & bus.lsu_bready;
    bus.lsu_bvalid = w_wr & bus.bvalid;
    bus.lsu_bresp = w_wr ? bus.bresp : 2'b00;
    bus.err = r_err;
  end
endmodule

// File: tb/tb_ysyx_25040129_axi_arbiter.sv
// tb_ysyx_25040129_axi_arbiter: scoreboard bench for the IFU/LSU AXI arbiter
module tb_ysyx_25040129_axi_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_25040129_axi_arbiter_if bus();
  ysyx_25040129_axi_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic        who;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_got, mon_exp;
  logic mon_v;
  int vec = 0;
  int miss = 0;
  int err_cnt = 0;
  int n;
  logic [31:0] a;
  logic [7:0] len;
  logic [2:0] sz;
  logic [1:0] bst;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.err) err_cnt++;
    for (int p = 0; p < 2; p++) begin
      mon_v = p == 1 ? (bus.lsu_rvalid & bus.lsu_rready) : (bus.ifu_rvalid & bus.ifu_rready);
      mon_got = p == 1 ? {1'b1, bus.lsu_rdata, bus.lsu_rresp, 1'b1} : {1'b0, bus.ifu_rdata, bus.ifu_rresp, bus.ifu_rlast};
      if (mon_v) begin
        vec++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL beat: got %h with no beat pending", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            miss++;
            $display("FAIL beat: got %h required %h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  task automatic serve_read(input int beats, input logic [1:0] resp, input int stall_at, input bit who,
                            output int waited, output logic [31:0] ad, output logic [7:0] ln,
                            output logic [2:0] sz_o, output logic [1:0] bs);
    beat_t e;
    int k = 0;
    while (!bus.arvalid && k < 20) begin
      tick;
      k++;
    end
    waited = k;
    ad = bus.araddr;
    ln = bus.arlen;
    sz_o = bus.arsize;
    bs = bus.arburst;
    if (!bus.arvalid) begin
      vec++;
      miss++;
      $display("FAIL ar_timeout: arvalid 0 after %0d cycles, required 1", k);
      return;
    end
    bus.arready = 1'b1;
    tick;
    bus.arready = 1'b0;
    if (who) bus.lsu_arvalid = 1'b0;
    else bus.ifu_arvalid = 1'b0;
    for (int b = 0; b < beats; b++) begin
      bus.rvalid = 1'b1;
      bus.rdata = $urandom;
      bus.rresp = resp;
      bus.rlast = b == beats - 1;
      e = {who, bus.rdata, resp, who ? 1'b1 : bus.rlast};
      exp_q.push_back(e);
      if (b == stall_at) begin
        bus.ifu_rready = 1'b0;
        bus.lsu_rready = 1'b0;
        tick;
        tick;
        bus.ifu_rready = 1'b1;
        bus.lsu_rready = 1'b1;
      end
      tick;
    end
    bus.rvalid = 1'b0;
    bus.rlast = 1'b0;
    bus.rresp = 2'b00;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    vec++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.ifu_arready, bus.ifu_rvalid,
         bus.lsu_arready, bus.lsu_rvalid, bus.lsu_awready, bus.lsu_wready, bus.lsu_bvalid, bus.err, bus.araddr} !== '0) begin
      miss++;
      $display("FAIL reset_outputs: some output nonzero (arvalid=%b rready=%b err=%b), required all 0", bus.arvalid, bus.rready, bus.err);
    end
    bus.rvalid = 1'b1;
    bus.bvalid = 1'b1;
    bus.arready = 1'b1;
    bus.wready = 1'b1;
    #1;
    vec++;
    if ({bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_bvalid, bus.ifu_arready, bus.lsu_arready, bus.lsu_wready} !== 6'd0) begin
      miss++;
      $display("FAIL idle_isolation: master outputs %b, required 000000",
               {bus.ifu_rvalid, bus.lsu_rvalid, bus.lsu_bvalid, bus.ifu_arready, bus.lsu_arready, bus.lsu_wready});
    end
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    bus.arready = 1'b0;
    bus.wready = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    err_cnt = 0;
    bus.ifu_araddr = 32'h3000_0100;
    bus.ifu_arlen = 8'd1;
    bus.ifu_arvalid = 1'b1;
    bus.lsu_araddr = 32'h8000_0040;
    bus.lsu_arsize = 3'b001;
    bus.lsu_arvalid = 1'b1;
    serve_read(1, 2'b00, -1, 1'b1, n, a, len, sz, bst);
    vec++;
    if ({a, len, sz, bst} !== {32'h8000_0040, 8'd0, 3'b001, 2'b01}) begin
      miss++;
      $display("FAIL lsu_first: ar %h/%h/%h/%h, required 80000040/00/1/1", a, len, sz, bst);
    end
    vec++;
    if (n !== 1) begin
      miss++;
      $display("FAIL grant_latency: %0d cycles, required 1", n);
    end
    vec++;
    if (bus.arvalid !== 1'b0) begin
      miss++;
      $display("FAIL bubble: arvalid %b right after completion, required 0", bus.arvalid);
    end
    serve_read(2, 2'b00, -1, 1'b0, n, a, len, sz, bst);
    vec++;
    if ({n[7:0], a, len, sz, bst} !== {8'd1, 32'h3000_0100, 8'd1, 3'b010, 2'b01}) begin
      miss++;
      $display("FAIL ifu_second: wait %0d ar %h/%h/%h/%h, required 1 30000100/01/2/1", n, a, len, sz, bst);
    end
    tick;
    vec++;
    if (err_cnt !== 0) begin
      miss++;
      $display("FAIL b2b_err: %0d err pulses, required 0", err_cnt);
    end
  endtask

  task automatic test_ifu_burst;
    err_cnt = 0;
    bus.ifu_araddr = 32'h3000_0000;
    bus.ifu_arlen = 8'd3;
    bus.ifu_arvalid = 1'b1;
    serve_read(4, 2'b00, 2, 1'b0, n, a, len, sz, bst);
    vec++;
    if ({n[7:0], a, len, sz, bst} !== {8'd1, 32'h3000_0000, 8'd3, 3'b010, 2'b01}) begin
      miss++;
      $display("FAIL ifu_ar: wait %0d ar %h/%h/%h/%h, required 1 30000000/03/2/1", n, a, len, sz, bst);
    end
    tick;
    vec++;
    if ({bus.arvalid, bus.rready, err_cnt[7:0], exp_q.size() == 0} !== {2'b00, 8'd0, 1'b1}) begin
      miss++;
      $display("FAIL ifu_done: arvalid=%b rready=%b err=%0d pending=%0d, required 0 0 0 0", bus.arvalid, bus.rready, err_cnt, exp_q.size());
    end
  endtask

  task automatic test_lsu_write;
    err_cnt = 0;
    bus.lsu_awaddr = 32'h8000_1000;
    bus.lsu_awvalid = 1'b1;
    bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_wstrb = 4'hF;
    bus.lsu_wvalid = 1'b1;
    bus.lsu_araddr = 32'h8000_2000;
    bus.lsu_arsize = 3'b010;
    bus.lsu_arvalid = 1'b1;
    tick;
    vec++;
    if ({bus.awvalid, bus.awaddr, bus.wvalid, bus.wdata, bus.wstrb} !== {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
      miss++;
      $display("FAIL wr_fwd: aw %b %h w %b %h %h, required 1 80001000 1 deadbeef f", bus.awvalid, bus.awaddr, bus.wvalid, bus.wdata, bus.wstrb);
    end
    bus.wready = 1'b1;
    bus.arready = 1'b1;
    #1;
    vec++;
    if ({bus.lsu_wready, bus.lsu_arready, bus.arvalid, bus.rready} !== 4'b1000) begin
      miss++;
      $display("FAIL wr_only: wready/arready/arvalid/rready %b, required 1000", {bus.lsu_wready, bus.lsu_arready, bus.arvalid, bus.rready});
    end
    tick;
    bus.lsu_wvalid = 1'b0;
    bus.wready = 1'b0;
    bus.arready = 1'b0;
    tick;
    bus.awready = 1'b1;
    #1;
    vec++;
    if ({bus.lsu_awready, bus.wvalid} !== 2'b10) begin
      miss++;
      $display("FAIL aw_late: awready=%b wvalid=%b, required 1 0", bus.lsu_awready, bus.wvalid);
    end
    tick;
    bus.awready = 1'b0;
    bus.lsu_awvalid = 1'b0;
    bus.bvalid = 1'b1;
    bus.bresp = 2'b00;
    bus.lsu_bready = 1'b0;
    tick;
    vec++;
    if ({bus.lsu_bvalid, bus.lsu_bresp, bus.bready} !== 4'b1000) begin
      miss++;
      $display("FAIL b_stall: bvalid=%b bresp=%b bready=%b, required 1 00 0", bus.lsu_bvalid, bus.lsu_bresp, bus.bready);
    end
    bus.lsu_bready = 1'b1;
    tick;
    bus.bvalid = 1'b0;
    serve_read(1, 2'b00, -1, 1'b1, n, a, len, sz, bst);
    vec++;
    if ({n[7:0], a} !== {8'd1, 32'h8000_2000}) begin
      miss++;
      $display("FAIL rd_after_wr: wait %0d addr %h, required 1 80002000", n, a);
    end
    tick;
    vec++;
    if (err_cnt !== 0) begin
      miss++;
      $display("FAIL wr_err: %0d err pulses, required 0", err_cnt);
    end
  endtask

  task automatic test_early_rlast;
    err_cnt = 0;
    bus.ifu_araddr = 32'h3000_0400;
    bus.ifu_arlen = 8'd3;
    bus.ifu_arvalid = 1'b1;
    serve_read(2, 2'b00, -1, 1'b0, n, a, len, sz, bst);
    vec++;
    if (bus.err !== 1'b1) begin
      miss++;
      $display("FAIL early_rlast_err: err=%b after short burst, required 1", bus.err);
    end
    tick;
    tick;
    vec++;
    if ({bus.err, bus.arvalid, err_cnt[7:0], exp_q.size() == 0} !== {2'b00, 8'd1, 1'b1}) begin
      miss++;
      $display("FAIL early_rlast_idle: err=%b arvalid=%b pulses=%0d pending=%0d, required 0 0 1 0", bus.err, bus.arvalid, err_cnt, exp_q.size());
    end
  endtask

  task automatic test_rresp_err;
    err_cnt = 0;
    bus.lsu_araddr = 32'h8000_3000;
    bus.lsu_arsize = 3'b000;
    bus.lsu_arvalid = 1'b1;
    serve_read(1, 2'b10, -1, 1'b1, n, a, len, sz, bst);
    vec++;
    if (bus.err !== 1'b1) begin
      miss++;
      $display("FAIL rresp_err: err=%b after SLVERR beat, required 1", bus.err);
    end
    tick;
    vec++;
    if ({bus.err, err_cnt[7:0]} !== {1'b0, 8'd1}) begin
      miss++;
      $display("FAIL rresp_pulse: err=%b pulses=%0d, required 0 1", bus.err, err_cnt);
    end
  endtask

  task automatic test_reset_mid_burst;
    beat_t e;
    err_cnt = 0;
    bus.ifu_araddr = 32'h3000_0200;
    bus.ifu_arlen = 8'd3;
    bus.ifu_arvalid = 1'b1;
    tick;
    vec++;
    if (bus.arvalid !== 1'b1) begin
      miss++;
      $display("FAIL mid_grant: arvalid=%b, required 1", bus.arvalid);
    end
    bus.arready = 1'b1;
    tick;
    bus.arready = 1'b0;
    bus.ifu_arvalid = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = $urandom;
    bus.rlast = 1'b0;
    e = {1'b0, bus.rdata, 2'b00, 1'b0};
    exp_q.push_back(e);
    tick;
    bus.rdata = 32'h1234_5678;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vec++;
    if ({bus.arvalid, bus.rready, bus.ifu_rvalid, bus.ifu_rdata, bus.ifu_rlast, bus.ifu_arready, bus.err} !== '0) begin
      miss++;
      $display("FAIL mid_reset: rready=%b ifu_rvalid=%b ifu_rdata=%h err=%b, required all 0", bus.rready, bus.ifu_rvalid, bus.ifu_rdata, bus.err);
    end
    tick;
    bus.rvalid = 1'b0;
    bus.lsu_araddr = 32'h8000_4000;
    bus.lsu_arsize = 3'b010;
    bus.lsu_arvalid = 1'b1;
    serve_read(1, 2'b00, -1, 1'b1, n, a, len, sz, bst);
    tick;
    vec++;
    if ({a, err_cnt[7:0], exp_q.size() == 0} !== {32'h8000_4000, 8'd0, 1'b1}) begin
      miss++;
      $display("FAIL post_reset_read: addr %h pulses %0d pending %0d, required 80004000 0 0", a, err_cnt, exp_q.size());
    end
  endtask

  initial begin
    {bus.ifu_araddr, bus.ifu_arlen, bus.ifu_arvalid} = '0;
    {bus.lsu_araddr, bus.lsu_arsize, bus.lsu_arvalid, bus.lsu_awaddr, bus.lsu_awvalid} = '0;
    {bus.lsu_wdata, bus.lsu_wstrb, bus.lsu_wvalid} = '0;
    {bus.arready, bus.rdata, bus.rresp, bus.rlast, bus.rvalid} = '0;
    {bus.awready, bus.wready, bus.bresp, bus.bvalid} = '0;
    bus.ifu_rready = 1'b1;
    bus.lsu_rready = 1'b1;
    bus.lsu_bready = 1'b1;
    test_reset;
    test_back_to_back;
    test_ifu_burst;
    test_lsu_write;
    test_early_rlast;
    test_rresp_err;
    test_reset_mid_burst;
    vec++;
    if (exp_q.size() != 0) begin
      miss++;
      $display("FAIL drain: %0d beats never delivered, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_25040129_axi_arbiter.md
# ysyx_25040129_axi_arbiter

Two-master AXI4 arbiter that shares the core's single memory port between the instruction fetch unit (IFU, read-only, burst-capable) and the load/store unit (LSU, single-beat read/write). It sits between the IFU/LSU and the crossbar. It grants one whole transaction at a time, using round-robin between masters. It checks burst length and response codes on the granted channel.

## Interface
- No parameters; address/data width fixed at 32.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `ifu_araddr`  in  32, `ifu_arlen`  in  8, `ifu_arvalid`  in  1, `ifu_arready`  out  1: IFU read address; arsize fixed 3'b010, arburst fixed INCR
- `ifu_rdata`  out  32, `ifu_rresp`  out  2, `ifu_rlast`  out  1, `ifu_rvalid`  out  1, `ifu_rready`  in  1: IFU read data
- `lsu_araddr`  in  32, `lsu_arsize`  in  3, `lsu_arvalid`  in  1, `lsu_arready`  out  1: LSU read address; arlen fixed 0
- `lsu_rdata`  out  32, `lsu_rresp`  out  2, `lsu_rvalid`  out  1, `lsu_rready`  in  1: LSU read data
- `lsu_awaddr`  in  32, `lsu_awvalid`  in  1, `lsu_awready`  out  1: LSU write address
- `lsu_wdata`  in  32, `lsu_wstrb`  in  4, `lsu_wvalid`  in  1, `lsu_wready`  out  1: LSU write data
- `lsu_bresp`  out  2, `lsu_bvalid`  out  1, `lsu_bready`  in  1: LSU write response
- `araddr`  out  32, `arsize`  out  3, `arlen`  out  8, `arburst`  out  2, `arvalid`  out  1, `arready`  in  1: downstream read address
- `rdata`  in  32, `rresp`  in  2, `rlast`  in  1, `rvalid`  in  1, `rready`  out  1: downstream read data
- `awaddr`  out  32, `awvalid`  out  1, `awready`  in  1, `wdata`  out  32, `wstrb`  out  4, `wvalid`  out  1, `wready`  in  1: downstream write
- `bresp`  in  2, `bvalid`  in  1, `bready`  out  1: downstream write response
- `err`  out  1: one-cycle pulse on a response or burst-length error

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. A registered `last_lsu` flag holds the owner of the previous grant.
- IDLE: all outputs to masters are 0 and all downstream valid/ready outputs are 0. Arbitration rules:
  - LSU request = `lsu_awvalid | lsu_arvalid`. Within the LSU, a write has priority over a read.
  - If only one master requests, that master wins.
  - If both request, IFU wins when `last_lsu`=1 and the LSU wins when `last_lsu`=0.
  - On a grant, `last_lsu` is updated and the beat counter is loaded with the granted arlen (0 for the LSU).
- IFU_RD / LSU_RD: the granted master's AR and R signals are connected combinationally to the downstream port. All other master-side handshake outputs stay 0. arburst=2'b01. The LSU read drives arlen=0; the IFU read drives arsize=3'b010.
- LSU_WR: AW, W and B are connected straight through. AW and W may complete in either cycle order.
- Beat counter (8 bits): decrements on each downstream `rvalid & rready`.
  - `rlast` arriving with counter≠0 → `err`.
  - Counter=0 beat without `rlast` → `err`. The state still waits for `rlast`.
- Any `rresp`≠2'b00 or `bresp`≠2'b00 on a completed handshake → `err`.
- Exit to IDLE: read states on `rvalid & rready & rlast`; LSU_WR on `bvalid & bready`.

## Timing
- Reset: state=IDLE, `last_lsu`=0, counter=0, `err`=0. Every output is 0 in IDLE.
- Reset mid-transaction: the transaction is abandoned and the block is in IDLE the next cycle. No beat is forwarded after reset.
- Grant latency: a request seen in IDLE at cycle N is forwarded downstream at cycle N+1. Minimum `*_arready` latency to the master is 1 cycle.
- After the final handshake at cycle M, the block is in IDLE at M+1. The earliest next grant is forwarded at M+2. Back-to-back transactions therefore have a 1-cycle bubble.
- All data-phase signals are combinational pass-through with zero added latency. A held `rready`=0 or `bready`=0 stalls without loss.
- Masters hold valid and payload until the handshake, per AXI. The arbiter never revokes a grant.
- `err` is registered and asserted for one cycle, the cycle after the offending handshake.

## Test plan
- IFU alone, araddr=0x3000_0000, arlen=3, 4 beats with rlast on the 4th → arvalid at cycle N+1, 4 ifu_rvalid beats, IDLE after the last beat, err=0.
- IFU and LSU read both requesting from reset → LSU granted first (last_lsu=0). The IFU is granted after LSU completion, with a 1-cycle bubble.
- LSU write, wdata=0xDEADBEEF, wstrb=4'hF, with wready 2 cycles before awready → lsu_bvalid passed through; no downstream read activity during LSU_WR.
- IFU burst arlen=3 but downstream rlast on beat 2 → err pulses once, state returns to IDLE.
- LSU read with rresp=2'b10 → lsu_rresp=2'b10 forwarded, err pulses one cycle later.
- rst asserted mid IFU burst → all outputs 0 the next cycle. A new LSU read afterwards completes normally.
